// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end. Owns the program counter, presents the word
//   address to the asynchronous instruction ROM and captures the returned
//   instruction into the IF/ID pipeline register. A two-state fetch FSM
//   (RUN/HALT) handles stalls, flushes, EX-stage redirects and traps on
//   misaligned redirect targets.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   i_stall          hold PC and IF/ID
//   i_flush          replace the instruction entering IF/ID with a bubble
//   i_branch_taken   EX-stage redirect request
//   i_branch_target  redirect byte address
//   IMEM_address     word index into IMEM, combinational from PC
//   Instruction      IMEM read data for IMEM_address (same cycle)
//   o_IF_ID_pc       PC of the registered instruction
//   o_IF_ID_pc4      that PC + 4
//   o_IF_ID_instr    registered instruction
//   o_IF_ID_valid    1 = real instruction, 0 = bubble
//   o_fetch_halted   FSM is in HALT
//   o_misaligned_exc sticky misaligned-redirect flag, cleared only by reset
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  output logic [PC_WIDTH-1:0] IMEM_address,
  input  logic [31:0]         Instruction,
  output logic [PC_WIDTH-1:0] o_IF_ID_pc,
  output logic [PC_WIDTH-1:0] o_IF_ID_pc4,
  output logic [31:0]         o_IF_ID_instr,
  output logic                o_IF_ID_valid,
  output logic                o_fetch_halted,
  output logic                o_misaligned_exc
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
  logic [PC_WIDTH-1:0]   ifid_pc4_q, ifid_pc4_d;
  logic [31:0]           ifid_instr_q, ifid_instr_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic [PC_WIDTH-1:0]   pc_plus4;

  // Natural wrap modulo 2^PC_WIDTH: 0xFFFF_FFFC + 4 = 0.
  assign pc_plus4     = pc_q + PC_WIDTH'(4);
  assign IMEM_address = {2'b00, pc_q[PC_WIDTH-1:2]};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    misaligned_d = misaligned_q;

    unique case (state_q)
      RUN: begin
        if (i_branch_taken) begin
          // The instruction in flight is wrong-path, so a redirect always
          // bubbles IF/ID and takes priority over a stall.
          if (i_branch_target[1:0] == 2'b00) begin
            pc_d = i_branch_target;
          end else begin
            misaligned_d = 1'b1;
            state_d      = HALT;
          end
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (i_stall) begin
          if (i_flush) begin
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end else begin
          pc_d       = pc_plus4;
          ifid_pc_d  = pc_q;
          ifid_pc4_d = pc_plus4;
          if (i_flush) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end else begin
            ifid_instr_d = Instruction;
            ifid_valid_d = 1'b1;
          end
        end
      end
      HALT: begin
        // Frozen until reset; keep feeding bubbles downstream.
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_plus4;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= RESET_PC;
      ifid_pc4_q   <= RESET_PC + PC_WIDTH'(4);
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_IF_ID_pc       = ifid_pc_q;
  assign o_IF_ID_pc4      = ifid_pc4_q;
  assign o_IF_ID_instr    = ifid_instr_q;
  assign o_IF_ID_valid    = ifid_valid_q;
  assign o_fetch_halted   = (state_q == HALT);
  assign o_misaligned_exc = misaligned_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit with a small combinational IMEM model.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = 32'h0;
  logic [31:0] IMEM_address;
  logic [31:0] Instruction;
  logic [31:0] o_IF_ID_pc;
  logic [31:0] o_IF_ID_pc4;
  logic [31:0] o_IF_ID_instr;
  logic        o_IF_ID_valid;
  logic        o_fetch_halted;
  logic        o_misaligned_exc;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .i_stall          (i_stall),
    .i_flush          (i_flush),
    .i_branch_taken   (i_branch_taken),
    .i_branch_target  (i_branch_target),
    .IMEM_address     (IMEM_address),
    .Instruction      (Instruction),
    .o_IF_ID_pc       (o_IF_ID_pc),
    .o_IF_ID_pc4      (o_IF_ID_pc4),
    .o_IF_ID_instr    (o_IF_ID_instr),
    .o_IF_ID_valid    (o_IF_ID_valid),
    .o_fetch_halted   (o_fetch_halted),
    .o_misaligned_exc (o_misaligned_exc)
  );

  always #5 clk = ~clk;

  // IMEM: four programmed words, everything else returns 0xEE in the top
  // byte and the low 24 bits of the word index.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    case (idx)
      32'd0:   rom_word = 32'h0010_0093;
      32'd1:   rom_word = 32'h0020_0113;
      32'd2:   rom_word = 32'h0030_0193;
      32'd3:   rom_word = 32'h0040_0213;
      default: rom_word = {8'hEE, idx[23:0]};
    endcase
  endfunction

  assign Instruction = rom_word(IMEM_address);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (IMEM_address !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want %h", IMEM_address, 32'h0); end
    checks++; if (o_IF_ID_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", o_IF_ID_pc, 32'h0); end
    checks++; if (o_IF_ID_pc4 !== 32'h4) begin errors++; $display("FAIL rst_pc4: got %h want %h", o_IF_ID_pc4, 32'h4); end
    checks++; if (o_IF_ID_instr !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h want %h", o_IF_ID_instr, 32'h13); end
    checks++; if (o_IF_ID_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_IF_ID_valid); end
    checks++; if (o_fetch_halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", o_fetch_halted); end
    checks++; if (o_misaligned_exc !== 1'b0) begin errors++; $display("FAIL rst_exc: got %b want 0", o_misaligned_exc); end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    step();
    checks++; if (IMEM_address !== 32'h1) begin errors++; $display("FAIL seq0_addr: got %h want %h", IMEM_address, 32'h1); end
    checks++; if (o_IF_ID_pc !== 32'h0) begin errors++; $display("FAIL seq0_pc: got %h want %h", o_IF_ID_pc, 32'h0); end
    checks++; if (o_IF_ID_pc4 !== 32'h4) begin errors++; $display("FAIL seq0_pc4: got %h want %h", o_IF_ID_pc4, 32'h4); end
    checks++; if (o_IF_ID_instr !== 32'h0010_0093) begin errors++; $display("FAIL seq0_instr: got %h want %h", o_IF_ID_instr, 32'h0010_0093); end
    checks++; if (o_IF_ID_valid !== 1'b1) begin errors++; $display("FAIL seq0_valid: got %b want 1", o_IF_ID_valid); end
    step();
    checks++; if (IMEM_address !== 32'h2) begin errors++; $display("FAIL seq1_addr: got %h want %h", IMEM_address, 32'h2); end
    checks++; if (o_IF_ID_pc !== 32'h4) begin errors++; $display("FAIL seq1_pc: got %h want %h", o_IF_ID_pc, 32'h4); end
    checks++; if (o_IF_ID_instr !== 32'h0020_0113) begin errors++; $display("FAIL seq1_instr: got %h want %h", o_IF_ID_instr, 32'h0020_0113); end
  endtask

  task automatic test_stall_flush();
    i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (IMEM_address !== 32'h2) begin errors++; $display("FAIL stall%0d_addr: got %h want %h", i, IMEM_address, 32'h2); end
      checks++; if (o_IF_ID_pc !== 32'h4) begin errors++; $display("FAIL stall%0d_pc: got %h want %h", i, o_IF_ID_pc, 32'h4); end
      checks++; if (o_IF_ID_instr !== 32'h0020_0113) begin errors++; $display("FAIL stall%0d_instr: got %h want %h", i, o_IF_ID_instr, 32'h0020_0113); end
      checks++; if (o_IF_ID_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid: got %b want 1", i, o_IF_ID_valid); end
    end
    i_flush = 1'b1;
    step();
    checks++; if (IMEM_address !== 32'h2) begin errors++; $display("FAIL sflush_addr: got %h want %h", IMEM_address, 32'h2); end
    checks++; if (o_IF_ID_instr !== 32'h13) begin errors++; $display("FAIL sflush_instr: got %h want %h", o_IF_ID_instr, 32'h13); end
    checks++; if (o_IF_ID_valid !== 1'b0) begin errors++; $display("FAIL sflush_valid: got %b want 0", o_IF_ID_valid); end
    checks++; if (o_IF_ID_pc !== 32'h8) begin errors++; $display("FAIL sflush_pc: got %h want %h", o_IF_ID_pc, 32'h8); end
    i_stall = 1'b0;
    i_flush = 1'b0;
    step();
    checks++; if (IMEM_address !== 32'h3) begin errors++; $display("FAIL resume_addr: got %h want %h", IMEM_address, 32'h3); end
    checks++; if (o_IF_ID_pc !== 32'h8) begin errors++; $display("FAIL resume_pc: got %h want %h", o_IF_ID_pc, 32'h8); end
    checks++; if (o_IF_ID_instr !== 32'h0030_0193) begin errors++; $display("FAIL resume_instr: got %h want %h", o_IF_ID_instr, 32'h0030_0193); end
    checks++; if (o_IF_ID_valid !== 1'b1) begin errors++; $display("FAIL resume_valid: got %b want 1", o_IF_ID_valid); end
  endtask

  task automatic test_redirect_beats_stall();
    i_branch_taken  = 1'b1;
    i_branch_target = 32'h40;
    i_stall         = 1'b1;
    step();
    i_branch_taken  = 1'b0;
    i_stall         = 1'b0;
    checks++; if (IMEM_address !== 32'h10) begin errors++; $display("FAIL redir_addr: got %h want %h", IMEM_address, 32'h10); end
    checks++; if (o_IF_ID_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", o_IF_ID_valid); end
    checks++; if (o_IF_ID_instr !== 32'h13) begin errors++; $display("FAIL redir_instr: got %h want %h", o_IF_ID_instr, 32'h13); end
    checks++; if (o_IF_ID_pc !== 32'hC) begin errors++; $display("FAIL redir_pc: got %h want %h", o_IF_ID_pc, 32'hC); end
    step();
    checks++; if (o_IF_ID_pc !== 32'h40) begin errors++; $display("FAIL tgt_pc: got %h want %h", o_IF_ID_pc, 32'h40); end
    checks++; if (o_IF_ID_pc4 !== 32'h44) begin errors++; $display("FAIL tgt_pc4: got %h want %h", o_IF_ID_pc4, 32'h44); end
    checks++; if (o_IF_ID_instr !== 32'hEE00_0010) begin errors++; $display("FAIL tgt_instr: got %h want %h", o_IF_ID_instr, 32'hEE00_0010); end
    checks++; if (o_IF_ID_valid !== 1'b1) begin errors++; $display("FAIL tgt_valid: got %b want 1", o_IF_ID_valid); end
    checks++; if (IMEM_address !== 32'h11) begin errors++; $display("FAIL tgt_addr: got %h want %h", IMEM_address, 32'h11); end
  endtask

  task automatic test_wrap();
    i_branch_taken  = 1'b1;
    i_branch_target = 32'hFFFF_FFFC;
    step();
    i_branch_taken  = 1'b0;
    checks++; if (IMEM_address !== 32'h3FFF_FFFF) begin errors++; $display("FAIL wrap_addr: got %h want %h", IMEM_address, 32'h3FFF_FFFF); end
    step();
    checks++; if (IMEM_address !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want %h", IMEM_address, 32'h0); end
    checks++; if (o_IF_ID_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want %h", o_IF_ID_pc, 32'hFFFF_FFFC); end
    checks++; if (o_IF_ID_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want %h", o_IF_ID_pc4, 32'h0); end
    checks++; if (o_IF_ID_instr !== 32'hEEFF_FFFF) begin errors++; $display("FAIL wrap_instr: got %h want %h", o_IF_ID_instr, 32'hEEFF_FFFF); end
    checks++; if (o_IF_ID_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", o_IF_ID_valid); end
  endtask

  task automatic test_misaligned();
    // PC is 0x0 here.
    i_branch_taken  = 1'b1;
    i_branch_target = 32'h42;
    step();
    checks++; if (o_misaligned_exc !== 1'b1) begin errors++; $display("FAIL mis_exc: got %b want 1", o_misaligned_exc); end
    checks++; if (o_fetch_halted !== 1'b1) begin errors++; $display("FAIL mis_halted: got %b want 1", o_fetch_halted); end
    checks++; if (IMEM_address !== 32'h0) begin errors++; $display("FAIL mis_addr: got %h want %h", IMEM_address, 32'h0); end
    checks++; if (o_IF_ID_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b want 0", o_IF_ID_valid); end
    i_branch_target = 32'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (o_fetch_halted !== 1'b1) begin errors++; $display("FAIL halt%0d_halted: got %b want 1", i, o_fetch_halted); end
      checks++; if (o_misaligned_exc !== 1'b1) begin errors++; $display("FAIL halt%0d_exc: got %b want 1", i, o_misaligned_exc); end
      checks++; if (IMEM_address !== 32'h0) begin errors++; $display("FAIL halt%0d_addr: got %h want %h", i, IMEM_address, 32'h0); end
      checks++; if (o_IF_ID_valid !== 1'b0) begin errors++; $display("FAIL halt%0d_valid: got %b want 0", i, o_IF_ID_valid); end
      checks++; if (o_IF_ID_instr !== 32'h13) begin errors++; $display("FAIL halt%0d_instr: got %h want %h", i, o_IF_ID_instr, 32'h13); end
    end
    i_branch_taken = 1'b0;
    reset = 1'b1;
    #2;
    checks++; if (o_misaligned_exc !== 1'b0) begin errors++; $display("FAIL misrst_exc: got %b want 0", o_misaligned_exc); end
    checks++; if (o_fetch_halted !== 1'b0) begin errors++; $display("FAIL misrst_halted: got %b want 0", o_fetch_halted); end
    reset = 1'b0;
    step();
    checks++; if (o_IF_ID_valid !== 1'b1) begin errors++; $display("FAIL misrel_valid: got %b want 1", o_IF_ID_valid); end
    checks++; if (o_IF_ID_pc !== 32'h0) begin errors++; $display("FAIL misrel_pc: got %h want %h", o_IF_ID_pc, 32'h0); end
    checks++; if (o_IF_ID_instr !== 32'h0010_0093) begin errors++; $display("FAIL misrel_instr: got %h want %h", o_IF_ID_instr, 32'h0010_0093); end
    checks++; if (IMEM_address !== 32'h1) begin errors++; $display("FAIL misrel_addr: got %h want %h", IMEM_address, 32'h1); end
  endtask

  task automatic test_async_reset();
    i_branch_taken  = 1'b1;
    i_branch_target = 32'h20;
    step();
    i_branch_taken  = 1'b0;
    checks++; if (IMEM_address !== 32'h8) begin errors++; $display("FAIL ar_pre_addr: got %h want %h", IMEM_address, 32'h8); end
    // Mid-cycle, well before the next rising edge.
    #2 reset = 1'b1;
    #1;
    checks++; if (IMEM_address !== 32'h0) begin errors++; $display("FAIL ar_addr: got %h want %h", IMEM_address, 32'h0); end
    checks++; if (o_IF_ID_pc !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h want %h", o_IF_ID_pc, 32'h0); end
    checks++; if (o_IF_ID_pc4 !== 32'h4) begin errors++; $display("FAIL ar_pc4: got %h want %h", o_IF_ID_pc4, 32'h4); end
    checks++; if (o_IF_ID_instr !== 32'h13) begin errors++; $display("FAIL ar_instr: got %h want %h", o_IF_ID_instr, 32'h13); end
    checks++; if (o_IF_ID_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", o_IF_ID_valid); end
    #1 reset = 1'b0;
    step();
    checks++; if (o_IF_ID_valid !== 1'b1) begin errors++; $display("FAIL arrel_valid: got %b want 1", o_IF_ID_valid); end
    checks++; if (o_IF_ID_pc !== 32'h0) begin errors++; $display("FAIL arrel_pc: got %h want %h", o_IF_ID_pc, 32'h0); end
    checks++; if (o_IF_ID_instr !== 32'h0010_0093) begin errors++; $display("FAIL arrel_instr: got %h want %h", o_IF_ID_instr, 32'h0010_0093); end
    checks++; if (IMEM_address !== 32'h1) begin errors++; $display("FAIL arrel_addr: got %h want %h", IMEM_address, 32'h1); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_flush();
    test_redirect_beats_stall();
    test_wrap();
    test_misaligned();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
